hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//  Pipeline sequencer for the 5-stage RV32I core. Sits beside Control_Unit: it keeps a shadow pipeline of
//  register metadata (rd, rs1/rs2, write-enable, is-load) and drives stage enables, flushes, forwarding selects,
//  memory-wait freeze, a memory timeout error and saturating stall/flush counters.
// PARAMETERS
//  CNT_W        16   width of the stall_cnt and flush_cnt performance counters (saturating)
//  MEM_TIMEOUT  64   consecutive dm_ready=0 cycles with a MEM-stage memory op before mem_err sets
// PORTS
//  clk          in   1   core clock; all state updates on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  id_rs1       in   5   rs1 of the instruction in ID
//  id_rs2       in   5   rs2 of the instruction in ID
//  id_use_rs1   in   1   ID instruction reads rs1
//  id_use_rs2   in   1   ID instruction reads rs2
//  id_rd        in   5   destination register of the ID instruction
//  id_rf_we     in   1   RF_we from Control_Unit for the ID instruction
//  id_is_load   in   1   ID instruction is LW
//  id_is_mem    in   1   ID instruction is LW or SW
//  ex_redirect  in   1   pcsel resolved in EX (taken branch, JAL, JALR)
//  dm_ready     in   1   data memory completes the MEM-stage access this cycle
//  pc_en        out  1   PC update enable
//  ifid_en      out  1   IF/ID register enable
//  ifid_flush   out  1   IF/ID loads a NOP
//  idex_en      out  1   ID/EX register enable
//  idex_flush   out  1   ID/EX loads a bubble
//  exmem_en     out  1   EX/MEM register enable
//  memwb_en     out  1   MEM/WB register enable
//  fwd_a_sel    out  2   EX operand A: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback value
//  fwd_b_sel    out  2   EX operand B: same encoding as fwd_a_sel
//  state        out  2   00 RUN, 01 LU_STALL, 10 FREEZE
//  mem_err      out  1   sticky memory-timeout flag
//  stall_cnt    out  CNT_W  cycles spent in LU_STALL or FREEZE
//  flush_cnt    out  CNT_W  redirect flushes taken
// BEHAVIOUR
//  Reset: rst_n=0 at a clock edge empties the shadow EX/MEM/WB entries (valid=0) and clears the timeout counter,
//   mem_err, stall_cnt and flush_cnt. Next state is RUN. After reset: all *_en=1, flushes=0, fwd_*_sel=00.
//  Shadow pipeline: on each advancing edge, MEM->WB and EX->MEM. EX takes the ID metadata, or a bubble when
//   idex_flush=1. Shadow entries advance on exactly the same enables as the datapath registers.
//  Forwarding (combinational, per EX operand): MEM entry valid, we=1, rd!=0, rd==ex_rs -> 01. Otherwise WB entry
//   matching under the same rule -> 10. Otherwise 00. MEM has priority over WB. A MEM-stage load is never
//   selected by 01; a load-use case always reaches WB first.
//  Load-use hazard: EX entry is a load with rd!=0, and (id_use_rs1 && id_rs1==rd) or (id_use_rs2 && id_rs2==rd).
//   Effect: pc_en=0, ifid_en=0, idex_flush=1, state=LU_STALL for exactly one cycle. The condition cannot
//   persist, because the load has moved to MEM.
//  Redirect: ex_redirect=1 gives ifid_flush=1, idex_flush=1 and pc_en=1, and increments flush_cnt.
//   Redirect beats load-use, since the stalled ID instruction is on the wrong path.
//  FREEZE: entered when the MEM entry is a memory op and dm_ready=0. All *_en=0 and all flushes are suppressed,
//   including a pending redirect; the datapath holds ex_redirect while EX is frozen. Exit is the cycle dm_ready=1.
//   FREEZE beats redirect, which beats load-use.
//  Timeout: the counter increments each FREEZE cycle and clears on exit. When it reaches MEM_TIMEOUT, mem_err
//   sets and stays set until reset. The freeze continues.
//  Counters: stall_cnt increments in LU_STALL and FREEZE cycles; both counters saturate at all-ones.
//  Mid-operation reset: any state returns to RUN next cycle with an empty shadow pipeline. No forwarding
//   from pre-reset entries.
// STRUCTURE
//  Package core_pkg: stage-state enum (RUN/LU_STALL/FREEZE); FWD_RF/FWD_MEM/FWD_WB constants; opcode constants
//   LW/SW shared with Control_Unit; shadow-entry struct {valid, rd, rs1, rs2, we, is_load, is_mem}.
//  One sub-module, hz_fwd_mux: the pure combinational forwarding comparator, instanced once per operand.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles, then x1..x3 traffic -> all en=1, fwd=00, counters 0, state RUN.
//  2 Forwarding: ADD x5 in EX/MEM, next op reads x5 as rs1 -> fwd_a_sel=01; two ops later -> 10; rd=x0 -> 00.
//  3 Load-use: LW x6 in EX, ID ADD rs2=x6 -> one cycle pc_en=0, idex_flush=1; next cycle fwd_b_sel=10,
//    stall_cnt=1.
//  4 Redirect + load-use in the same cycle -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
//  5 LW in MEM with dm_ready=0 for 3 cycles, ex_redirect=1 -> all en=0, no flush; on dm_ready=1 the redirect
//    flush happens; stall_cnt=3.
//  6 dm_ready=0 for MEM_TIMEOUT cycles -> mem_err=1 on that cycle, held after exit; rst_n=0 -> mem_err=0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module : core_pkg
//  Brief  : Shared types and constants for the RV32I pipeline sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FREEZE   = 2'b10
    } stage_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Opcodes shared with Control_Unit
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       we;
        logic       is_load;
        logic       is_mem;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '0;

endpackage : core_pkg
`default_nettype wire

// File: rtl/hz_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module : hz_fwd_mux
//  Brief  : Forwarding-source comparator for one EX operand.
//  Rev    : 1.0  initial release
// ============================================================================
module hz_fwd_mux
    import core_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic       mem_valid,
    input  logic       mem_we,
    input  logic       mem_is_load,
    input  logic [4:0] mem_rd,
    input  logic       wb_valid,
    input  logic       wb_we,
    input  logic [4:0] wb_rd,
    output logic [1:0] sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Load data is not available from EX/MEM; a consumer only sees it from WB
    assign w_mem_hit = mem_valid && mem_we && !mem_is_load &&
                       (mem_rd != 5'd0) && (mem_rd == ex_rs);
    assign w_wb_hit  = wb_valid && wb_we && (wb_rd != 5'd0) && (wb_rd == ex_rs);

    always_comb begin
        sel = FWD_RF;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule : hz_fwd_mux
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : hazard_sequencer
//  Brief  : Stage enables, flushes, forwarding and memory-wait freeze for the
//           5-stage RV32I core, driven by a shadow pipeline of register use.
//  Rev    : 1.0  initial release
// ============================================================================
module hazard_sequencer
    import core_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             id_is_mem,
    input  logic             ex_redirect,
    input  logic             dm_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    shadow_t          w_id_ent;
    stage_state_e     w_state;
    logic             w_freeze;
    logic             w_load_use;
    logic [TMO_W-1:0] r_tmo;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_unused_wb;

    assign w_id_ent = '{valid:   1'b1,
                        rd:      id_rd,
                        rs1:     id_rs1,
                        rs2:     id_rs2,
                        we:      id_rf_we,
                        is_load: id_is_load,
                        is_mem:  id_is_mem};

    assign w_freeze   = r_mem.valid && r_mem.is_mem && !dm_ready;
    assign w_load_use = r_ex.valid && r_ex.is_load && (r_ex.rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == r_ex.rd)) ||
                         (id_use_rs2 && (id_rs2 == r_ex.rd)));

    // Mode priority: freeze, then redirect (stays in RUN), then load-use
    always_comb begin
        w_state = ST_RUN;
        if (w_freeze) begin
            w_state = ST_FREEZE;
        end else if (!ex_redirect && w_load_use) begin
            w_state = ST_LU_STALL;
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        case (w_state)
            ST_FREEZE: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            ST_LU_STALL: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            default: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex        <= SHADOW_EMPTY;
            r_mem       <= SHADOW_EMPTY;
            r_wb        <= SHADOW_EMPTY;
            r_tmo       <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (idex_en) begin
                r_ex <= idex_flush ? SHADOW_EMPTY : w_id_ent;
            end
            if (exmem_en) begin
                r_mem <= r_ex;
            end
            if (memwb_en) begin
                r_wb <= r_mem;
            end

            // Timeout counter parks at MEM_TIMEOUT so a long freeze cannot wrap it
            if (w_freeze) begin
                if (r_tmo != TMO_W'(MEM_TIMEOUT)) begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
                if (r_tmo >= TMO_W'(MEM_TIMEOUT - 1)) begin
                    r_mem_err <= 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end

            if ((w_state != ST_RUN) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ex_redirect && !w_freeze && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    hz_fwd_mux u_fwd_a (
        .ex_rs       (r_ex.rs1),
        .mem_valid   (r_mem.valid),
        .mem_we      (r_mem.we),
        .mem_is_load (r_mem.is_load),
        .mem_rd      (r_mem.rd),
        .wb_valid    (r_wb.valid),
        .wb_we       (r_wb.we),
        .wb_rd       (r_wb.rd),
        .sel         (fwd_a_sel)
    );

    hz_fwd_mux u_fwd_b (
        .ex_rs       (r_ex.rs2),
        .mem_valid   (r_mem.valid),
        .mem_we      (r_mem.we),
        .mem_is_load (r_mem.is_load),
        .mem_rd      (r_mem.rd),
        .wb_valid    (r_wb.valid),
        .wb_we       (r_wb.we),
        .wb_rd       (r_wb.rd),
        .sel         (fwd_b_sel)
    );

    // WB operand fields are carried only for debug visibility
    assign w_unused_wb = ^{r_wb.rs1, r_wb.rs2, r_wb.is_load, r_wb.is_mem};

    assign state     = w_state;
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : hazard_sequencer
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_hazard_sequencer
//  Brief  : Randomized and directed bench for hazard_sequencer with a
//           behavioural pipeline model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_sequencer;

    localparam int CNT_W = 6;
    localparam int TO    = 12;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2, id_rf_we, id_is_load, id_is_mem;
    logic             ex_redirect, dm_ready;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic [1:0]       fwd_a_sel, fwd_b_sel, state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load), .id_is_mem(id_is_mem),
        .ex_redirect(ex_redirect), .dm_ready(dm_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model: index 0=EX, 1=MEM, 2=WB ----------------
    typedef struct {
        bit v;
        int rd;
        int rs1;
        int rs2;
        bit we;
        bit ld;
        bit mem;
    } ent_t;

    ent_t pipe [3];
    int   m_tmo, m_stall, m_flush;
    bit   m_err;
    bit   e_freeze, e_hazard;

    function automatic int fwd_of(int rs);
        if (pipe[1].v && pipe[1].we && !pipe[1].ld && pipe[1].rd != 0 && pipe[1].rd == rs) return 1;
        if (pipe[2].v && pipe[2].we && pipe[2].rd != 0 && pipe[2].rd == rs) return 2;
        return 0;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic compute();
        int rd;
        rd = pipe[0].rd;
        e_freeze = pipe[1].v && pipe[1].mem && !dm_ready;
        e_hazard = pipe[0].v && pipe[0].ld && rd != 0 &&
                   ((id_use_rs1 && int'(id_rs1) == rd) || (id_use_rs2 && int'(id_rs2) == rd));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        m_tmo = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic settle();
        logic [6:0] exp_ctl;
        int         exp_st;
        #1;
        compute();
        if (e_freeze) begin
            exp_ctl = 7'b0000000; exp_st = 2;
        end else if (ex_redirect) begin
            exp_ctl = 7'b1111111; exp_st = 0;
        end else if (e_hazard) begin
            exp_ctl = 7'b0001111; exp_st = 1;
        end else begin
            exp_ctl = 7'b1101011; exp_st = 0;
        end
        chk("ctl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}, exp_ctl);
        chk("state", state, exp_st);
        chk("fwd_a", fwd_a_sel, fwd_of(int'(pipe[0].rs1)));
        chk("fwd_b", fwd_b_sel, fwd_of(int'(pipe[0].rs2)));
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic advance();
        @(posedge clk);
        compute();
        if (!rst_n) begin
            model_reset();
        end else if (e_freeze) begin
            m_tmo++;
            if (m_tmo >= TO) m_err = 1;
            m_stall = sat_inc(m_stall);
        end else begin
            m_tmo   = 0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (ex_redirect || e_hazard) pipe[0] = '{default: 0};
            else pipe[0] = '{v: 1, rd: int'(id_rd), rs1: int'(id_rs1), rs2: int'(id_rs2),
                             we: id_rf_we, ld: id_is_load, mem: id_is_mem};
            if (ex_redirect) m_flush = sat_inc(m_flush);
            else if (e_hazard) m_stall = sat_inc(m_stall);
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit u1, input int r1, input bit u2, input int r2,
                          input int rd, input bit we, input bit ld, input bit mem);
        id_use_rs1 = u1; id_rs1 = 5'(r1);
        id_use_rs2 = u2; id_rs2 = 5'(r2);
        id_rd = 5'(rd); id_rf_we = we; id_is_load = ld; id_is_mem = mem;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse(input int n);
        rst_n = 1'b0;
        repeat (n) advance();
        rst_n = 1'b1;
    endtask

    task automatic lw_to_mem(input int rd);
        set_id(1, 0, 0, 0, rd, 1, 1, 1);
        settle(); advance();
        nop();
        settle(); advance();
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; ex_redirect = 1'b0; dm_ready = 1'b1;
        nop();
        @(negedge clk);

        // Reset then independent traffic writing x1..x3
        reset_pulse(2);
        for (int r = 1; r <= 3; r++) begin
            set_id(1, 0, 1, 0, r, 1, 0, 0);
            settle();
            chk("rst_ctl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}, 7'b1101011);
            chk("rst_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
            chk("rst_state", state, 2'b00);
            chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
            advance();
        end

        // Forwarding: MEM, WB, and x0 never forwards
        reset_pulse(1);
        set_id(1, 1, 1, 2, 5, 1, 0, 0); settle(); advance();
        set_id(1, 5, 1, 3, 6, 1, 0, 0); settle(); advance();
        set_id(1, 4, 1, 5, 7, 1, 0, 0); settle();
        chk("fwd_a_mem", fwd_a_sel, 2'b01);
        advance();
        set_id(1, 1, 1, 2, 0, 1, 0, 0); settle();
        chk("fwd_b_wb", fwd_b_sel, 2'b10);
        advance();
        set_id(1, 0, 1, 0, 9, 1, 0, 0); settle(); advance();
        nop(); settle();
        chk("fwd_a_x0", fwd_a_sel, 2'b00);
        advance();

        // Load-use: one stall cycle, then WB forward
        reset_pulse(1);
        set_id(1, 1, 0, 0, 6, 1, 1, 1); settle(); advance();
        set_id(1, 2, 1, 6, 8, 1, 0, 0); settle();
        chk("lu_pc_en", pc_en, 1'b0);
        chk("lu_idex_flush", idex_flush, 1'b1);
        chk("lu_state", state, 2'b01);
        advance();
        settle(); advance();
        nop(); settle();
        chk("lu_fwd_b", fwd_b_sel, 2'b10);
        chk("lu_stall_cnt", stall_cnt, 1);
        advance();

        // Redirect beats load-use
        reset_pulse(1);
        set_id(1, 1, 0, 0, 6, 1, 1, 1); settle(); advance();
        set_id(1, 2, 1, 6, 8, 1, 0, 0); ex_redirect = 1'b1; settle();
        chk("rd_ctl", {pc_en, ifid_flush, idex_flush}, 3'b111);
        advance();
        ex_redirect = 1'b0; nop(); settle();
        chk("rd_flush_cnt", flush_cnt, 1);
        chk("rd_stall_cnt", stall_cnt, 0);
        advance();

        // Freeze holds a pending redirect until dm_ready
        reset_pulse(1);
        lw_to_mem(7);
        dm_ready = 1'b0; ex_redirect = 1'b1;
        repeat (3) begin
            settle();
            chk("frz_ctl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}, 7'b0000000);
            chk("frz_state", state, 2'b10);
            advance();
        end
        dm_ready = 1'b1; settle();
        chk("frz_exit_flush", {ifid_flush, idex_flush, pc_en}, 3'b111);
        advance();
        ex_redirect = 1'b0; settle();
        chk("frz_stall_cnt", stall_cnt, 3);
        chk("frz_flush_cnt", flush_cnt, 1);
        advance();

        // Timeout: clears on exit, sets after TO cycles, sticky until reset
        reset_pulse(1);
        lw_to_mem(9);
        dm_ready = 1'b0;
        repeat (TO - 1) begin settle(); advance(); end
        dm_ready = 1'b1; settle();
        chk("tmo_below", mem_err, 1'b0);
        advance();
        lw_to_mem(9);
        dm_ready = 1'b0;
        repeat (TO - 1) begin settle(); advance(); end
        settle();
        chk("tmo_edge_minus1", mem_err, 1'b0);
        advance();
        settle();
        chk("tmo_set", mem_err, 1'b1);
        advance();
        repeat (60) begin settle(); advance(); end
        settle();
        chk("stall_sat", stall_cnt, SAT);
        dm_ready = 1'b1; advance();
        settle();
        chk("tmo_sticky", mem_err, 1'b1);
        reset_pulse(1);
        settle();
        chk("tmo_reset", mem_err, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit ld, st;
            ld = ($urandom_range(0, 3) == 0);
            st = !ld && ($urandom_range(0, 4) == 0);
            set_id(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7),
                   $urandom_range(0, 7), ld || (!st && 1'($urandom_range(0, 1))), ld, ld || st);
            ex_redirect = ($urandom_range(0, 7) == 0);
            dm_ready    = ($urandom_range(0, 3) != 0);
            rst_n       = ($urandom_range(0, 63) != 0);
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_sequencer
`default_nettype wire
